// File: rtl/ev_logger_ts.sv
// ev_logger_ts: captures filtered event codes with a free-running cycle
// timestamp into a show-ahead FIFO. The FIFO is drained, the filter is
// programmed and control flags are set through the GPIO_OUT/csrStrobe pair.
module ev_logger_ts #(
    parameter int unsigned CODE_WIDTH = 8,
    parameter int unsigned TS_WIDTH   = 24,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter string       DEBUG      = "false"
) (
    input  logic                  sysClk,
    input  logic                  sysReset,
    input  logic                  evValid,
    input  logic                  evIsK,
    input  logic [CODE_WIDTH-1:0] evCode,
    input  logic [31:0]           GPIO_OUT,
    input  logic                  csrStrobe,
    output logic [31:0]           status,
    output logic [31:0]           timestamp,
    output logic [DEPTH_LOG2:0]   fillLevel
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned NUM_CODES = 1 << CODE_WIDTH;
    localparam int unsigned LVL_W     = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam bit          DEBUG_ON  = (DEBUG == "true");

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [CODE_WIDTH-1:0] code;
    } entry_t;

    (* mark_debug = DEBUG *) logic [TS_WIDTH-1:0]   ts_cnt;
    (* mark_debug = DEBUG *) logic [NUM_CODES-1:0]  filter;
    (* mark_debug = DEBUG *) logic                  enable;
    (* mark_debug = DEBUG *) logic                  pend_valid;
    (* mark_debug = DEBUG *) entry_t                pend_entry;
    (* mark_debug = DEBUG *) logic [DEPTH_LOG2-1:0] wr_ptr;
    (* mark_debug = DEBUG *) logic [DEPTH_LOG2-1:0] rd_ptr;
    (* mark_debug = DEBUG *) logic [LVL_W-1:0]      count;
    (* mark_debug = DEBUG *) logic [15:0]           dropped;
    (* mark_debug = DEBUG *) logic                  overflow;

    entry_t mem [DEPTH];

    logic                  csr_pop;
    logic                  csr_clear;
    logic                  csr_filt;
    logic                  csr_en;
    logic [CODE_WIDTH-1:0] filt_idx;
    logic                  empty;
    logic                  full;
    logic                  accept;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_drop;
    logic [LVL_W-1:0]      count_nxt;
    entry_t                head;
    logic                  unused_bits;

    // CSR field decode; clear overrides pop and write within the same strobe
    always_comb begin
        csr_pop   = csrStrobe && GPIO_OUT[8];
        csr_clear = csrStrobe && GPIO_OUT[9];
        csr_filt  = csrStrobe && GPIO_OUT[10];
        csr_en    = csrStrobe && GPIO_OUT[13];
        filt_idx  = GPIO_OUT[CODE_WIDTH-1:0];
        empty     = (count == '0);
        full      = (count == FULL_LEVEL);
        accept    = evValid && !evIsK && enable && filter[evCode] && (evCode != '0);
        do_pop    = csr_pop && !empty && !csr_clear;
        do_push   = pend_valid && (!full || do_pop) && !csr_clear;
        do_drop   = pend_valid && !do_push && !csr_clear;
    end

    // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - LVL_W'(1);
        end
    end

    // Free-running timestamp plus the filter and enable control registers
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            ts_cnt <= '0;
            filter <= '1;
            enable <= 1'b1;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (csr_filt) begin
                filter[filt_idx] <= GPIO_OUT[11];
            end
            if (csr_en) begin
                enable <= GPIO_OUT[12];
            end
        end
    end

    // Stage register holding the accepted event for one cycle before the write
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else begin
            pend_valid <= accept && !csr_clear;
            if (accept) begin
                pend_entry <= '{ts: ts_cnt, code: evCode};
            end
        end
    end

    // FIFO pointers, occupancy and drop accounting
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else if (csr_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count_nxt;
            if (do_drop) begin
                overflow <= 1'b1;
                if (dropped != 16'hFFFF) begin
                    dropped <= dropped + 16'd1;
                end
            end
        end
    end

    // Entry storage; contents need no reset because empty masks the head
    always_ff @(posedge sysClk) begin
        if (do_push) begin
            mem[wr_ptr] <= pend_entry;
        end
    end

    // Show-ahead head and status assembly, all derived from registered state
    always_comb begin
        head      = empty ? '0 : mem[rd_ptr];
        status    = {dropped, 4'b0000, overflow, enable, full, empty, 8'(head.code)};
        timestamp = 32'(head.ts);
        fillLevel = count;
    end

    // Upper CSR bits are reserved; DEBUG only feeds the mark_debug attributes
    assign unused_bits = ^{GPIO_OUT[31:14], DEBUG_ON};

endmodule

// File: tb/tb_ev_logger_ts.sv
// tb_ev_logger_ts: scoreboard bench for ev_logger_ts. Two instances share the
// stimulus: one with a 24-bit timestamp, one with a 4-bit timestamp; both
// have a 4-entry FIFO.
module tb_ev_logger_ts;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_isk   = 1'b0;
    logic [7:0]  ev_code  = 8'h00;
    logic [31:0] gpio     = 32'h0;
    logic        strobe   = 1'b0;

    logic [31:0] status_a, ts_a, status_b, ts_b;
    logic [2:0]  fill_a, fill_b;

    ev_logger_ts #(.CODE_WIDTH(8), .TS_WIDTH(24), .DEPTH_LOG2(2), .DEBUG("false")) dut_a (
        .sysClk(clk), .sysReset(rst), .evValid(ev_valid), .evIsK(ev_isk), .evCode(ev_code),
        .GPIO_OUT(gpio), .csrStrobe(strobe), .status(status_a), .timestamp(ts_a),
        .fillLevel(fill_a)
    );

    ev_logger_ts #(.CODE_WIDTH(8), .TS_WIDTH(4), .DEPTH_LOG2(2), .DEBUG("false")) dut_b (
        .sysClk(clk), .sysReset(rst), .evValid(ev_valid), .evIsK(ev_isk), .evCode(ev_code),
        .GPIO_OUT(gpio), .csrStrobe(strobe), .status(status_b), .timestamp(ts_b),
        .fillLevel(fill_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [23:0] ts;
    } ent_t;

    // Reference state: queue of stored entries plus the pending stage and flags
    ent_t         q[$];
    logic         m_pend;
    ent_t         m_pend_e;
    logic [15:0]  m_drop;
    logic         m_ovf;
    logic         m_en;
    logic [255:0] m_filt;
    logic [23:0]  m_ts;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [7:0] hc;
        hc = (q.size() == 0) ? 8'h00 : q[0].code;
        return {m_drop, 4'b0000, m_ovf, m_en, (q.size() == 4), (q.size() == 0), hc};
    endfunction

    task automatic check_all();
        ent_t h;
        h.code = 8'h00;
        h.ts   = 24'h0;
        if (q.size() != 0) h = q[0];
        check_val("status_a", status_a, exp_status());
        check_val("status_b", status_b, exp_status());
        check_val("ts_a", ts_a, 32'(h.ts));
        check_val("ts_b", ts_b, {28'h0, h.ts[3:0]});
        check_val("fill_a", 32'(fill_a), 32'(q.size()));
        check_val("fill_b", 32'(fill_b), 32'(q.size()));
    endtask

    task automatic model_reset();
        q.delete();
        m_pend        = 1'b0;
        m_pend_e.code = 8'h00;
        m_pend_e.ts   = 24'h0;
        m_drop        = 16'h0;
        m_ovf         = 1'b0;
        m_en          = 1'b1;
        m_filt        = '1;
        m_ts          = 24'h0;
    endtask

    // One clock cycle: drive inputs, advance the reference at the edge, compare
    task automatic cyc(input logic v, input logic k, input logic [7:0] c,
                       input logic s, input logic [31:0] d);
        logic pop, clr, acc, full;
        ev_valid = v;
        ev_isk   = k;
        ev_code  = c;
        strobe   = s;
        gpio     = d;
        pop  = s && d[8] && (q.size() > 0);
        clr  = s && d[9];
        acc  = v && !k && m_en && m_filt[c] && (c != 8'h00);
        full = (q.size() == 4);
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_pend = 1'b0;
            m_drop = 16'h0;
            m_ovf  = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_pend) begin
                if (!full || pop) begin
                    q.push_back(m_pend_e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            m_pend = acc;
        end
        if (acc) begin
            m_pend_e.code = c;
            m_pend_e.ts   = m_ts;
        end
        if (s && d[10]) m_filt[d[7:0]] = d[11];
        if (s && d[13]) m_en = d[12];
        m_ts = m_ts + 24'd1;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic ev(input logic [7:0] c);
        cyc(1'b1, 1'b0, c, 1'b0, 32'h0);
    endtask

    task automatic csr(input logic [31:0] d);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, d);
    endtask

    logic [3:0] t_prev;

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_status", status_a, 32'h0000_0500);
        check_val("rst_ts", ts_a, 32'h0);
        check_val("rst_fill", 32'(fill_a), 32'h0);
        rst = 1'b0;

        // Codes 0x01, 0x05, 0x00 starting at timestamp 100
        idle(100);
        ev(8'h01);
        check_val("t1_not_yet", 32'(status_a[8]), 32'h1);
        ev(8'h05);
        check_val("t1_vis_code", 32'(status_a[7:0]), 32'h01);
        check_val("t1_vis_ts", ts_a, 32'd100);
        ev(8'h00);
        idle(2);
        check_val("t1_fill", 32'(fill_a), 32'd2);
        csr(32'h0000_0100);
        check_val("t1_second_ts", ts_a, 32'd101);
        csr(32'h0000_0100);
        check_val("t1_empty", 32'(status_a[8]), 32'h1);

        // K characters and the enable bit
        cyc(1'b1, 1'b1, 8'h07, 1'b0, 32'h0);
        csr(32'h0000_2000);
        ev(8'h08);
        idle(2);
        check_val("en_off_fill", 32'(fill_a), 32'h0);
        csr(32'h0000_3000);

        // Per-code filter
        csr(32'h0000_0470);
        ev(8'h70);
        ev(8'h71);
        idle(2);
        check_val("filt_fill", 32'(fill_a), 32'd1);
        check_val("filt_head", 32'(status_a[7:0]), 32'h71);
        csr(32'h0000_0100);
        csr(32'h0000_0C70);
        ev(8'h70);
        idle(2);
        check_val("filt_readmit", 32'(status_a[7:0]), 32'h70);
        csr(32'h0000_0100);

        // Overflow: six events into four entries
        for (int i = 0; i < 6; i++) ev(8'h11 + 8'(i));
        idle(2);
        check_val("ovf_status", status_a, 32'h0002_0E11);
        check_val("ovf_fill", 32'(fill_a), 32'd4);

        // Pop while full in the write cycle of a new event
        ev(8'h21);
        csr(32'h0000_0100);
        check_val("fullpop_status", status_a, 32'h0002_0E12);
        check_val("fullpop_fill", 32'(fill_a), 32'd4);

        // Clear together with pop while an event is pending
        ev(8'h42);
        csr(32'h0000_0300);
        check_val("clr_status", status_a, 32'h0000_0500);
        check_val("clr_fill", 32'(fill_a), 32'h0);
        idle(3);
        check_val("clr_no_pend", status_a, 32'h0000_0500);

        // 4-bit timestamp wrap: events 15 cycles apart
        ev(8'h31);
        idle(14);
        ev(8'h32);
        idle(14);
        ev(8'h33);
        idle(2);
        for (int i = 0; i < 2; i++) begin
            t_prev = ts_b[3:0];
            csr(32'h0000_0100);
            check_val("wrap_ts", 32'(ts_b[3:0]), 32'(4'(t_prev - 4'd1)));
        end
        csr(32'h0000_0100);

        // Asynchronous reset with three entries stored
        ev(8'h51);
        ev(8'h52);
        ev(8'h53);
        idle(2);
        check_val("pre_rst_fill", 32'(fill_a), 32'd3);
        rst = 1'b1;
        #1;
        check_val("arst_status_a", status_a, 32'h0000_0500);
        check_val("arst_status_b", status_b, 32'h0000_0500);
        check_val("arst_ts", ts_a, 32'h0);
        check_val("arst_fill", 32'(fill_a), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        ev(8'h61);
        idle(2);
        csr(32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ev_logger_ts.md
# ev_logger_ts

Timestamped, filtered event logger. It captures event codes from an event stream that is already in the system clock domain. Each accepted code is stored with a free-running cycle timestamp in an internal show-ahead FIFO, which the processor drains through the standard GPIO_OUT/csrStrobe CSR pair. It supersedes the fixed 8-bit, fixed-filter logger: code width, timestamp width and depth are parameters, and it adds a per-code programmable filter, an enable bit and a dropped-event counter.

## Interface
- CODE_WIDTH, 8: event code width, legal range 1..8.
- TS_WIDTH, 24: timestamp width, legal range 1..32.
- DEPTH_LOG2, 9: FIFO holds 2^DEPTH_LOG2 entries.
- DEBUG, "false": mark_debug attribute value on internal state.
- sysClk  in  1  sole clock; all logic is synchronous to its rising edge.
- sysReset  in  1  reset, asynchronous and active-high.
- evValid  in  1  event qualifier for this cycle.
- evIsK  in  1  the event character is a K (control) character; such events are never logged.
- evCode  in  CODE_WIDTH  event code.
- GPIO_OUT  in  32  CSR write data.
- csrStrobe  in  1  CSR write strobe, one cycle per write.
- status  out  32  head code, flags and dropped count.
- timestamp  out  32  head timestamp, zero-extended.
- fillLevel  out  DEPTH_LOG2+1  current entry count.

## Operation
- Timestamp counter: TS_WIDTH bits, increments every cycle, wraps modulo 2^TS_WIDTH, resets to 0.
- Filter: a register array of 2^CODE_WIDTH bits, reset to all ones. Code 0 is always rejected, whatever its filter bit says.
- Accept condition in cycle n: evValid && !evIsK && enable && filter[evCode] && evCode != 0.
  - An accepted event is captured into stage register {tsCounter value at cycle n, evCode}, with a pending flag set.
- Write stage, cycle n+1:
  - If pending and (fillLevel < 2^DEPTH_LOG2 or a pop occurs this cycle), the entry is written.
  - Otherwise the entry is dropped: the dropped count increments, saturating at 0xFFFF, and overflow is set.
- CSR write (csrStrobe high). Each field acts independently within one strobe.
  - GPIO_OUT[8] pop: advance the head. Ignored when empty.
  - GPIO_OUT[9] clear: flush the FIFO and the pending stage, zero the dropped count, clear overflow. Clear wins over a simultaneous pop or write. The timestamp counter and filter are not affected.
  - GPIO_OUT[10] filter write: filter[GPIO_OUT[CODE_WIDTH-1:0]] <= GPIO_OUT[11]. The new value applies to events sampled from the next cycle onward.
  - GPIO_OUT[13] enable-write: enable <= GPIO_OUT[12]. enable resets to 1.
- status bit fields:
  - [7:0]: head code, zero-extended.
  - [8]: empty.
  - [9]: full.
  - [10]: enable.
  - [11]: overflow (sticky).
  - [15:12]: 0.
  - [31:16]: dropped count.
- When the FIFO is empty, the head code and timestamp outputs read 0.
- Reset values:
  - status = 0x0000_0500 (empty=1, enable=1).
  - timestamp = 0.
  - fillLevel = 0.
  - Pending flag, pointers, counters and overflow all 0.

## Timing
- Event sampled at cycle n, entry written at the edge ending cycle n+1. When the FIFO was previously empty, empty=0 and valid head code and timestamp appear in cycle n+2.
- fillLevel updates in the same cycle as the write, i.e. it is visible from cycle n+2.
- Pop strobe in cycle p: the next head (or empty=1) is visible in cycle p+1. fillLevel decrements in cycle p+1.
- Push and pop in the same cycle: fillLevel is unchanged. This also holds when full, because the write is accepted.
- Throughput: one accepted event per cycle, sustained.
- The pointers wrap modulo 2^DEPTH_LOG2. full is asserted when fillLevel == 2^DEPTH_LOG2.
- Asynchronous reset mid-operation drops the pending entry and every stored entry. Outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then inject codes 0x01, 0x05 and 0x00 on consecutive cycles starting at tsCounter=100.
  - Expected: two entries, (0x01, ts 100) and (0x05, ts 101). Code 0 is not logged.
  - The first entry is visible two cycles after injection. Two pops leave empty=1.
- Filter write code 0x70 to 0, then inject 0x70 and 0x71.
  - Expected: only 0x71 is logged. Writing the filter bit back to 1 re-admits 0x70.
- With DEPTH_LOG2=2, inject 6 events and do not pop.
  - Expected: fillLevel=4, full=1, overflow=1, dropped count=2. The head is still the first event.
- With the FIFO full, pop in the same cycle a new event is written.
  - Expected: the event is accepted, fillLevel stays 4 and the dropped count is unchanged.
- With TS_WIDTH=4, log events 15 cycles apart.
  - Expected: each timestamp is the previous one minus 1, modulo 16 (wrap-around).
- Issue clear in the same strobe as a pop while an event is in the pending stage.
  - Expected: empty=1, fillLevel=0, dropped count=0, overflow=0. The pending event is not logged.
- Assert asynchronous reset with 3 entries stored.
  - Expected: status=0x0000_0500 without waiting for a clock edge.
